// File: rtl/macc_drain_pkg.sv
// Shared definitions for the MACC result drain: state encoding, stage select codes,
// default word width and a constant clog2 helper.
package macc_drain_pkg;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_SEND = 1'b1
    } drain_state_t;

    localparam int DRAIN_WIDTH = 32;

    // One-hot stage select; any other code holds the stage.
    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_LOAD  = 2'b01;
    localparam logic [1:0] SEL_SHIFT = 2'b10;

    function automatic int drain_clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/macc_drain_stage.sv
// One element of the drain chain: a WIDTH-bit register that either captures its
// parallel word, takes its neighbour's value, or holds.
module drain_stage
    import macc_drain_pkg::*;
#(
    parameter int WIDTH = DRAIN_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] par_word,
    input  logic [WIDTH-1:0] next_word,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q <= '0;
        end else begin
            case (sel)
                SEL_LOAD:  q <= par_word;
                SEL_SHIFT: q <= next_word;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/macc_drain.sv
// Parallel-load, serial-unload drain: captures DEPTH words at once and streams
// them lowest index first over a valid/ready handshake.
module macc_drain
    import macc_drain_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DRAIN_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   VDD,
    input  logic                   GND,
    input  logic                   load,
    input  logic [DEPTH*WIDTH-1:0] din,
    output logic                   busy,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [WIDTH-1:0]       dout,
    output logic                   dout_last
);

    localparam int REM_W = drain_clog2(DEPTH + 1);

    drain_state_t                  state;
    logic [REM_W-1:0]              rem;
    logic [1:0]                    sel;
    logic [DEPTH-1:0][WIDTH-1:0]   w;
    logic                          unused_power;

    assign unused_power = VDD ^ GND;

    always_comb begin
        sel = SEL_HOLD;
        if (state == DRAIN_IDLE && load) begin
            sel = SEL_LOAD;
        end else if (state == DRAIN_SEND && dout_ready) begin
            sel = SEL_SHIFT;
        end
    end

    // The tail stage shifts in zeros, so stage 0 reads 0 once the burst is gone.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] next_word;
        if (i == DEPTH - 1) begin : g_tail
            assign next_word = '0;
        end else begin : g_mid
            assign next_word = w[i+1];
        end
        drain_stage #(.WIDTH(WIDTH)) u_stage (
            .CLK       (CLK),
            .RST       (RST),
            .sel       (sel),
            .par_word  (din[i*WIDTH +: WIDTH]),
            .next_word (next_word),
            .q         (w[i])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= DRAIN_IDLE;
            rem   <= '0;
        end else begin
            case (state)
                DRAIN_IDLE: begin
                    if (load) begin
                        rem   <= REM_W'(DEPTH);
                        state <= DRAIN_SEND;
                    end
                end
                DRAIN_SEND: begin
                    if (dout_ready) begin
                        rem <= rem - 1'b1;
                        if (rem == REM_W'(1)) begin
                            state <= DRAIN_IDLE;
                        end
                    end
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

    assign busy       = (state == DRAIN_SEND);
    assign dout_valid = busy;
    assign dout       = w[0];
    assign dout_last  = busy && (rem == REM_W'(1));

endmodule

// File: tb/tb_macc_drain.sv
// Bench for macc_drain: directed bursts plus random traffic on a DEPTH=4 build
// against a word-queue model, and a directed DEPTH=1 build.
module tb_macc_drain;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST;
    logic VDD;
    logic GND;

    logic         load4;
    logic [127:0] din4;
    logic         ready4;
    logic         busy4;
    logic         valid4;
    logic [31:0]  dout4;
    logic         last4;

    logic         load1;
    logic [31:0]  din1;
    logic         ready1;
    logic         busy1;
    logic         valid1;
    logic [31:0]  dout1;
    logic         last1;

    int checks   = 0;
    int failures = 0;

    // Words still owed by the DEPTH=4 drain, front is what dout must show.
    logic [31:0] expQ[$];

    macc_drain #(.DEPTH(4), .WIDTH(32)) dut4 (
        .CLK        (CLK),
        .RST        (RST),
        .VDD        (VDD),
        .GND        (GND),
        .load       (load4),
        .din        (din4),
        .busy       (busy4),
        .dout_valid (valid4),
        .dout_ready (ready4),
        .dout       (dout4),
        .dout_last  (last4)
    );

    macc_drain #(.DEPTH(1), .WIDTH(32)) dut1 (
        .CLK        (CLK),
        .RST        (RST),
        .VDD        (VDD),
        .GND        (GND),
        .load       (load1),
        .din        (din1),
        .busy       (busy1),
        .dout_valid (valid1),
        .dout_ready (ready1),
        .dout       (dout1),
        .dout_last  (last1)
    );

    task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string phase);
        logic        expBusy;
        logic [31:0] expWord;
        logic        expLast;
        expBusy = (expQ.size() != 0);
        expWord = expBusy ? expQ[0] : 32'h0;
        expLast = (expQ.size() == 1);
        compareValue({phase, " busy"},  {31'b0, busy4},  {31'b0, expBusy});
        compareValue({phase, " valid"}, {31'b0, valid4}, {31'b0, expBusy});
        compareValue({phase, " dout"},  dout4,           expWord);
        compareValue({phase, " last"},  {31'b0, last4},  {31'b0, expLast});
    endtask

    // Check current outputs, drive one cycle of inputs, then advance the model.
    task automatic applyStimulus(input logic ld, input logic [127:0] d, input logic rdy, input string phase);
        @(negedge CLK);
        checkOutput(phase);
        load4  = ld;
        din4   = d;
        ready4 = rdy;
        @(posedge CLK);
        if (expQ.size() != 0) begin
            if (rdy) void'(expQ.pop_front());
        end else if (ld) begin
            for (int i = 0; i < 4; i++) expQ.push_back(d[i*32 +: 32]);
        end
    endtask

    localparam logic [127:0] BURST_A = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [127:0] BURST_B = {32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1};
    localparam logic [127:0] BURST_C = {32'h0C0C0004, 32'h0C0C0003, 32'h0C0C0002, 32'h0C0C0001};
    localparam logic [127:0] BEEF    = {4{32'hDEADBEEF}};

    initial begin
        logic [1:0]   readySeq;
        logic [6:0]   togglePattern;
        logic [127:0] rnd;
        VDD    = 1'b1;
        GND    = 1'b0;
        RST    = 1'b1;
        load4  = 1'b0;
        din4   = '0;
        ready4 = 1'b0;
        load1  = 1'b0;
        din1   = '0;
        ready1 = 1'b0;

        #1;
        checkOutput("reset");
        compareValue("reset d1 busy", {31'b0, busy1}, 32'h0);
        compareValue("reset d1 dout", dout1, 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        $display("[TB] burst with ready held high");
        applyStimulus(1'b1, BURST_A, 1'b1, "load A");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, "drain A");
        applyStimulus(1'b0, '0, 1'b1, "idle after A");

        $display("[TB] burst with ready toggling");
        togglePattern = 7'b1101001;
        applyStimulus(1'b1, BURST_A, 1'b0, "load toggle");
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, togglePattern[i], "toggle");
        applyStimulus(1'b0, '0, 1'b0, "idle after toggle");

        $display("[TB] load pulsed during SEND");
        applyStimulus(1'b1, BURST_B, 1'b0, "load B");
        applyStimulus(1'b1, BEEF, 1'b1, "beef 0");
        applyStimulus(1'b1, BEEF, 1'b0, "beef 1");
        applyStimulus(1'b1, BEEF, 1'b1, "beef 2");
        applyStimulus(1'b1, BEEF, 1'b1, "beef 3");
        applyStimulus(1'b0, BEEF, 1'b1, "beef 4");
        applyStimulus(1'b0, '0, 1'b1, "idle after B");

        $display("[TB] load on last transfer");
        applyStimulus(1'b1, BURST_A, 1'b1, "load last");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, "drain last");
        applyStimulus(1'b1, BURST_B, 1'b1, "load on last xfer");
        applyStimulus(1'b1, BURST_C, 1'b1, "reload");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, "drain reload");

        $display("[TB] asynchronous reset mid-burst");
        applyStimulus(1'b1, BURST_B, 1'b0, "load pre-reset");
        applyStimulus(1'b0, '0, 1'b1, "xfer pre-reset");
        applyStimulus(1'b0, '0, 1'b1, "xfer pre-reset");
        @(negedge CLK);
        checkOutput("before reset");
        #2 RST = 1'b1;
        #1;
        expQ.delete();
        checkOutput("async reset");
        @(negedge CLK);
        RST = 1'b0;
        applyStimulus(1'b1, BURST_C, 1'b1, "load post-reset");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, "drain post-reset");

        $display("[TB] DEPTH=1 build");
        @(negedge CLK);
        load1  = 1'b1;
        din1   = 32'hCAFEF00D;
        ready1 = 1'b1;
        @(negedge CLK);
        compareValue("d1 busy",  {31'b0, busy1},  32'h1);
        compareValue("d1 valid", {31'b0, valid1}, 32'h1);
        compareValue("d1 dout",  dout1,           32'hCAFEF00D);
        compareValue("d1 last",  {31'b0, last1},  32'h1);
        load1 = 1'b0;
        @(negedge CLK);
        compareValue("d1 busy after", {31'b0, busy1},  32'h0);
        compareValue("d1 valid after", {31'b0, valid1}, 32'h0);
        compareValue("d1 dout after", dout1,           32'h0);
        compareValue("d1 last after", {31'b0, last1},  32'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 300; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            readySeq = 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 3) == 0, rnd, readySeq != 2'b00, "random");
        end
        for (int n = 0; n < 5; n++) applyStimulus(1'b0, '0, 1'b1, "final drain");
        @(negedge CLK);
        checkOutput("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
